// File: rtl/sc_frog_pkg.sv
// Shared encodings and width helper for the grid-aware Frogger game controller.
package sc_frog_pkg;

  localparam int unsigned ST_W = 4;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_RESET    = 4'd0;
  localparam state_t ST_IDLE     = 4'd1;
  localparam state_t ST_INIT     = 4'd2;
  localparam state_t ST_CHECK    = 4'd3;
  localparam state_t ST_MOVE     = 4'd4;
  localparam state_t ST_RELEASE  = 4'd5;
  localparam state_t ST_DIE      = 4'd6;
  localparam state_t ST_LEVELUP  = 4'd7;
  localparam state_t ST_GAMEOVER = 4'd8;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  // Index width for a dimension of n entries, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/sc_statemachine_frog_if.sv
// Button/collision inputs and position/status outputs between the game controller and the playfield.
interface sc_statemachine_frog_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  import sc_frog_pkg::*;

  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);

  logic          startButton_InLow;
  logic          upButton_InLow;
  logic          downButton_InLow;
  logic          leftButton_InLow;
  logic          rightButton_InLow;
  logic          collision_InLow;
  logic [RW-1:0] row_Out;
  logic [CW-1:0] col_Out;
  logic [3:0]    lives_Out;
  logic [3:0]    level_Out;
  logic          clear_OutLow;
  logic          move_OutLow;
  logic          dead_OutLow;
  logic          levelUp_OutLow;
  logic          playing_Out;
  logic          gameOver_Out;
  logic          win_Out;

  modport master (
    input  startButton_InLow, upButton_InLow, downButton_InLow,
           leftButton_InLow, rightButton_InLow, collision_InLow,
    output row_Out, col_Out, lives_Out, level_Out,
           clear_OutLow, move_OutLow, dead_OutLow, levelUp_OutLow,
           playing_Out, gameOver_Out, win_Out
  );

  modport slave (
    output startButton_InLow, upButton_InLow, downButton_InLow,
           leftButton_InLow, rightButton_InLow, collision_InLow,
    input  row_Out, col_Out, lives_Out, level_Out,
           clear_OutLow, move_OutLow, dead_OutLow, levelUp_OutLow,
           playing_Out, gameOver_Out, win_Out
  );

endinterface

// File: rtl/sc_repeat_timer.sv
// Held-button auto-repeat timer; expired_c flags the last count of the repeat period.
module sc_repeat_timer
  import sc_frog_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  if (REPEAT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clear, enable};
    assign expired_c = 1'b0;
  end else begin : g_on
    localparam int unsigned TW = idx_w(REPEAT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(REPEAT_CYCLES - 1);

    logic [TW-1:0] count;

    // Saturates at LAST so a stalled consumer never sees a wrap.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                           count <= '0;
      else if (clear)                    count <= '0;
      else if (enable && count != LAST)  count <= count + TW'(1);
    end

    assign expired_c = (count == LAST);
  end

endmodule

// File: rtl/sc_statemachine_frog.sv
// Frogger game controller: frog position on a ROWS x COLS grid, lives, levels and event strobes.
module sc_statemachine_frog
  import sc_frog_pkg::*;
#(
  parameter int unsigned COLS          = 8,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned START_COL     = 3,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LEVELS        = 4,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input logic                    SC_STATEMACHINEFROG_CLOCK_50,
  input logic                    SC_STATEMACHINEFROG_RESET_InHigh,
  sc_statemachine_frog_if.master bus
);

  localparam int unsigned   RW         = idx_w(ROWS);
  localparam int unsigned   CW         = idx_w(COLS);
  localparam logic [RW-1:0] ROW_START  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_START  = CW'(START_COL);
  localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
  localparam logic [3:0]    LEVEL_LAST = 4'(LEVELS - 1);

  logic clk;
  logic rst;
  assign clk = SC_STATEMACHINEFROG_CLOCK_50;
  assign rst = SC_STATEMACHINEFROG_RESET_InHigh;

  state_t        state, state_nxt;
  dir_t          dir, dir_sel;
  logic [RW-1:0] row, row_mv;
  logic [CW-1:0] col, col_mv;
  logic [3:0]    lives, level;
  logic          win;

  logic          clear_n, move_n, dead_n, levelup_n, playing, game_over;
  logic          clear_n_nxt, move_n_nxt, dead_n_nxt, levelup_n_nxt, playing_nxt, game_over_nxt;

  logic [3:0]    dir_btn_n;
  logic          all_released, held, rpt_expired;

  assign dir_btn_n    = {bus.rightButton_InLow, bus.leftButton_InLow,
                         bus.downButton_InLow, bus.upButton_InLow};
  assign held         = ~dir_btn_n[dir];
  assign all_released = bus.startButton_InLow & (&dir_btn_n);

  // Repeat count restarts on every RELEASE entry and whenever the latched button lets go.
  sc_repeat_timer #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_repeat (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state != ST_RELEASE) || !held),
    .enable    (held),
    .expired_c (rpt_expired)
  );

  // Target position for the latched direction; CHECK only latches legal moves.
  always_comb begin
    row_mv = row;
    col_mv = col;
    case (dir)
      DIR_UP:    row_mv = row - RW'(1);
      DIR_DOWN:  row_mv = row + RW'(1);
      DIR_LEFT:  col_mv = col - CW'(1);
      DIR_RIGHT: col_mv = col + CW'(1);
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dir_sel   = dir;
    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE:  if (!bus.startButton_InLow) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_RELEASE;
      ST_CHECK: begin
        // Blocked directions fall through to the next button in priority order.
        if (!bus.collision_InLow)                             state_nxt = ST_DIE;
        else if (!bus.startButton_InLow)                      state_nxt = ST_INIT;
        else if (!bus.upButton_InLow && row != '0) begin
          state_nxt = ST_MOVE; dir_sel = DIR_UP;
        end else if (!bus.downButton_InLow && row != ROW_START) begin
          state_nxt = ST_MOVE; dir_sel = DIR_DOWN;
        end else if (!bus.leftButton_InLow && col != '0) begin
          state_nxt = ST_MOVE; dir_sel = DIR_LEFT;
        end else if (!bus.rightButton_InLow && col != COL_MAX) begin
          state_nxt = ST_MOVE; dir_sel = DIR_RIGHT;
        end
      end
      ST_MOVE:     state_nxt = (row_mv == '0) ? ST_LEVELUP : ST_RELEASE;
      ST_RELEASE: begin
        if (!bus.collision_InLow)      state_nxt = ST_DIE;
        else if (all_released)         state_nxt = ST_CHECK;
        else if (held && rpt_expired)  state_nxt = ST_CHECK;
      end
      ST_DIE:      state_nxt = (lives <= 4'd1) ? ST_GAMEOVER : ST_RELEASE;
      ST_LEVELUP:  state_nxt = (level == LEVEL_LAST) ? ST_GAMEOVER : ST_RELEASE;
      ST_GAMEOVER: if (!bus.startButton_InLow) state_nxt = ST_INIT;
      default:     state_nxt = ST_RESET;
    endcase
  end

  // Moore outputs decoded from the upcoming state so the flops track the state register.
  always_comb begin
    clear_n_nxt   = 1'b1;
    move_n_nxt    = 1'b1;
    dead_n_nxt    = 1'b1;
    levelup_n_nxt = 1'b1;
    playing_nxt   = 1'b0;
    game_over_nxt = 1'b0;
    case (state_nxt)
      ST_INIT:     clear_n_nxt = 1'b0;
      ST_CHECK:    playing_nxt = 1'b1;
      ST_MOVE:     begin move_n_nxt = 1'b0;    playing_nxt = 1'b1; end
      ST_RELEASE:  playing_nxt = 1'b1;
      ST_DIE:      begin dead_n_nxt = 1'b0;    playing_nxt = 1'b1; end
      ST_LEVELUP:  begin levelup_n_nxt = 1'b0; playing_nxt = 1'b1; end
      ST_GAMEOVER: game_over_nxt = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_n   <= 1'b1;
      move_n    <= 1'b1;
      dead_n    <= 1'b1;
      levelup_n <= 1'b1;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      clear_n   <= clear_n_nxt;
      move_n    <= move_n_nxt;
      dead_n    <= dead_n_nxt;
      levelup_n <= levelup_n_nxt;
      playing   <= playing_nxt;
      game_over <= game_over_nxt;
    end
  end

  // Game datapath: updates on the edge that leaves INIT/CHECK/MOVE/DIE/LEVELUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row   <= ROW_START;
      col   <= COL_START;
      lives <= LIVES_INIT;
      level <= '0;
      win   <= 1'b0;
      dir   <= DIR_UP;
    end else begin
      case (state)
        ST_INIT: begin
          row   <= ROW_START;
          col   <= COL_START;
          lives <= LIVES_INIT;
          level <= '0;
          win   <= 1'b0;
        end
        ST_CHECK: dir <= dir_sel;
        ST_MOVE: begin
          row <= row_mv;
          col <= col_mv;
        end
        ST_DIE: begin
          lives <= lives - 4'd1;
          if (state_nxt == ST_RELEASE) begin
            row <= ROW_START;
            col <= COL_START;
          end
        end
        ST_LEVELUP: begin
          if (state_nxt == ST_GAMEOVER) begin
            win <= 1'b1;
          end else begin
            level <= level + 4'd1;
            row   <= ROW_START;
            col   <= COL_START;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.row_Out        = row;
  assign bus.col_Out        = col;
  assign bus.lives_Out      = lives;
  assign bus.level_Out      = level;
  assign bus.win_Out        = win;
  assign bus.clear_OutLow   = clear_n;
  assign bus.move_OutLow    = move_n;
  assign bus.dead_OutLow    = dead_n;
  assign bus.levelUp_OutLow = levelup_n;
  assign bus.playing_Out    = playing;
  assign bus.gameOver_Out   = game_over;

endmodule

// File: tb/tb_sc_statemachine_frog.sv
// Scoreboard bench: dut_a uses defaults (no auto-repeat, 4 levels), dut_b uses REPEAT_CYCLES=4, LEVELS=2.
module tb_sc_statemachine_frog;

  localparam int B_START = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4, B_COLL = 5;
  localparam int K_CLEAR = 0, K_MOVE = 1, K_DEAD = 2, K_LVLUP = 3;

  typedef struct {
    int dut, kind, row, col, lives, level, win, over, gap;
  } exp_t;

  typedef struct {
    int row, col, lives, level, clr, mv, dead, lvl, play, over, win;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] bn [2];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;

  exp_t sbq[$];
  exp_t pend_e [2];
  bit   pend [2];
  int   last_mv [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  sc_statemachine_frog_if #(.ROWS(8), .COLS(8)) ifa ();
  sc_statemachine_frog_if #(.ROWS(8), .COLS(8)) ifb ();

  assign ifa.startButton_InLow = bn[0][B_START];
  assign ifa.upButton_InLow    = bn[0][B_UP];
  assign ifa.downButton_InLow  = bn[0][B_DOWN];
  assign ifa.leftButton_InLow  = bn[0][B_LEFT];
  assign ifa.rightButton_InLow = bn[0][B_RIGHT];
  assign ifa.collision_InLow   = bn[0][B_COLL];
  assign ifb.startButton_InLow = bn[1][B_START];
  assign ifb.upButton_InLow    = bn[1][B_UP];
  assign ifb.downButton_InLow  = bn[1][B_DOWN];
  assign ifb.leftButton_InLow  = bn[1][B_LEFT];
  assign ifb.rightButton_InLow = bn[1][B_RIGHT];
  assign ifb.collision_InLow   = bn[1][B_COLL];

  sc_statemachine_frog #(.COLS(8), .ROWS(8), .START_COL(3), .LIVES(3), .LEVELS(4), .REPEAT_CYCLES(0)) dut_a (
    .SC_STATEMACHINEFROG_CLOCK_50     (clk),
    .SC_STATEMACHINEFROG_RESET_InHigh (rst),
    .bus                              (ifa.master)
  );

  sc_statemachine_frog #(.COLS(8), .ROWS(8), .START_COL(3), .LIVES(3), .LEVELS(2), .REPEAT_CYCLES(4)) dut_b (
    .SC_STATEMACHINEFROG_CLOCK_50     (clk),
    .SC_STATEMACHINEFROG_RESET_InHigh (rst),
    .bus                              (ifb.master)
  );

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.row = int'(ifa.row_Out);   o.col = int'(ifa.col_Out);
      o.lives = int'(ifa.lives_Out); o.level = int'(ifa.level_Out);
      o.clr = int'(ifa.clear_OutLow); o.mv = int'(ifa.move_OutLow);
      o.dead = int'(ifa.dead_OutLow); o.lvl = int'(ifa.levelUp_OutLow);
      o.play = int'(ifa.playing_Out); o.over = int'(ifa.gameOver_Out); o.win = int'(ifa.win_Out);
    end else begin
      o.row = int'(ifb.row_Out);   o.col = int'(ifb.col_Out);
      o.lives = int'(ifb.lives_Out); o.level = int'(ifb.level_Out);
      o.clr = int'(ifb.clear_OutLow); o.mv = int'(ifb.move_OutLow);
      o.dead = int'(ifb.dead_OutLow); o.lvl = int'(ifb.levelUp_OutLow);
      o.play = int'(ifb.playing_Out); o.over = int'(ifb.gameOver_Out); o.win = int'(ifb.win_Out);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int d, input int b, input int hold, input int gap);
    bn[d][b] = 1'b0;
    tick(hold);
    bn[d][b] = 1'b1;
    tick(gap);
  endtask

  task automatic expect_ev(input int d, input int k, input int r, input int c, input int l,
                           input int lv, input int w, input int o, input int g);
    exp_t e;
    e.dut = d; e.kind = k; e.row = r; e.col = c; e.lives = l;
    e.level = lv; e.win = w; e.over = o; e.gap = g;
    sbq.push_back(e);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    obs_t o;
    o = sample(d);
    chk({tag, "_row"}, o.row, 7);     chk({tag, "_col"}, o.col, 3);
    chk({tag, "_lives"}, o.lives, 3); chk({tag, "_level"}, o.level, 0);
    chk({tag, "_clear_n"}, o.clr, 1); chk({tag, "_move_n"}, o.mv, 1);
    chk({tag, "_dead_n"}, o.dead, 1); chk({tag, "_lvlup_n"}, o.lvl, 1);
    chk({tag, "_playing"}, o.play, 0); chk({tag, "_gameover"}, o.over, 0);
    chk({tag, "_win"}, o.win, 0);
  endtask

  // Monitor: a strobe pops the next expectation; the state it leads to is checked one cycle later.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t o;
      exp_t e;
      int   k;
      string t;
      o = sample(d);
      if (pend[d]) begin
        e = pend_e[d];
        pend[d] = 1'b0;
        t = $sformatf("d%0d_k%0d", d, e.kind);
        chk({t, "_row"}, o.row, e.row);       chk({t, "_col"}, o.col, e.col);
        chk({t, "_lives"}, o.lives, e.lives); chk({t, "_level"}, o.level, e.level);
        chk({t, "_win"}, o.win, e.win);       chk({t, "_gameover"}, o.over, e.over);
        chk({t, "_playing"}, o.play, (e.over != 0) ? 0 : 1);
      end
      k = (o.clr == 0) ? K_CLEAR : (o.mv == 0) ? K_MOVE : (o.dead == 0) ? K_DEAD :
          (o.lvl == 0) ? K_LVLUP : -1;
      if (k >= 0) begin
        if (sbq.size() == 0) begin
          chk($sformatf("d%0d_unexpected_strobe_k%0d", d, k), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_dut", d, e.dut);
          chk($sformatf("d%0d_strobe_kind", d), k, e.kind);
          if (k == K_MOVE) begin
            if (e.gap > 0) chk($sformatf("d%0d_move_gap", d), cycle - last_mv[d], e.gap);
            last_mv[d] = cycle;
          end
          pend[d]   = 1'b1;
          pend_e[d] = e;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    bn[0] = 6'h3f;
    bn[1] = 6'h3f;
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_mv[0] = 0; last_mv[1] = 0;
    tick(2);
    check_reset_vals(0, "rst_a");
    check_reset_vals(1, "rst_b");
    rst = 1'b0;
    tick(2);

    // dut_a: start, then five left presses from col 3 clamp at col 0
    expect_ev(0, K_CLEAR, 7, 3, 3, 0, 0, 0, 0);
    press(0, B_START, 2, 3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) expect_ev(0, K_MOVE, 7, 2 - i, 3, 0, 0, 0, 0);
      press(0, B_LEFT, 2, 3);
    end
    o = sample(0);
    chk("a_left_clamp_col", o.col, 0);

    press(0, B_DOWN, 2, 3);
    o = sample(0);
    chk("a_down_blocked_row", o.row, 7);

    // long hold without auto-repeat: exactly one step
    expect_ev(0, K_MOVE, 7, 1, 3, 0, 0, 0, 0);
    press(0, B_RIGHT, 20, 3);
    o = sample(0);
    chk("a_hold_single_step_col", o.col, 1);

    // collision beats a simultaneous up press
    expect_ev(0, K_DEAD, 7, 3, 2, 0, 0, 0, 0);
    bn[0][B_UP] = 1'b0;
    bn[0][B_COLL] = 1'b0;
    tick(1);
    bn[0][B_UP] = 1'b1;
    bn[0][B_COLL] = 1'b1;
    tick(3);

    expect_ev(0, K_MOVE, 6, 3, 2, 0, 0, 0, 0);
    press(0, B_UP, 2, 3);
    expect_ev(0, K_DEAD, 7, 3, 1, 0, 0, 0, 0);
    press(0, B_COLL, 1, 3);
    expect_ev(0, K_DEAD, 7, 3, 0, 0, 0, 1, 0);
    press(0, B_COLL, 1, 3);
    press(0, B_UP, 2, 2);
    expect_ev(0, K_CLEAR, 7, 3, 3, 0, 0, 0, 0);
    press(0, B_START, 2, 3);

    // dut_b: two levels of seven up presses, second clears the game
    expect_ev(1, K_CLEAR, 7, 3, 3, 0, 0, 0, 0);
    press(1, B_START, 2, 3);
    for (int lv = 0; lv < 2; lv++) begin
      for (int k = 1; k <= 7; k++) begin
        expect_ev(1, K_MOVE, 7 - k, 3, 3, lv, 0, 0, 0);
        if (k == 7) begin
          if (lv == 0) expect_ev(1, K_LVLUP, 7, 3, 3, 1, 0, 0, 0);
          else         expect_ev(1, K_LVLUP, 0, 3, 3, 1, 1, 1, 0);
        end
        press(1, B_UP, 2, 3);
      end
    end
    expect_ev(1, K_CLEAR, 7, 3, 3, 0, 0, 0, 0);
    press(1, B_START, 2, 3);

    // auto-repeat: held right steps every 6 cycles and stops at col 7
    expect_ev(1, K_MOVE, 7, 4, 3, 0, 0, 0, 0);
    expect_ev(1, K_MOVE, 7, 5, 3, 0, 0, 0, 6);
    expect_ev(1, K_MOVE, 7, 6, 3, 0, 0, 0, 6);
    expect_ev(1, K_MOVE, 7, 7, 3, 0, 0, 0, 6);
    press(1, B_RIGHT, 40, 3);
    o = sample(1);
    chk("b_repeat_clamp_col", o.col, 7);

    // reset while dut_a sits in RELEASE holding left
    expect_ev(0, K_MOVE, 7, 2, 3, 0, 0, 0, 0);
    bn[0][B_LEFT] = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check_reset_vals(0, "midrst_a");
    tick(2);
    bn[0][B_LEFT] = 1'b1;
    rst = 1'b0;
    tick(3);
    press(0, B_UP, 2, 3);
    o = sample(0);
    chk("a_idle_after_reset_row", o.row, 7);
    chk("a_idle_after_reset_playing", o.play, 0);
    expect_ev(0, K_CLEAR, 7, 3, 3, 0, 0, 0, 0);
    press(0, B_START, 2, 3);

    tick(3);
    chk("sb_outstanding", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_frog.md
# sc_statemachine_frog

Parametrised Frogger game controller. Replaces the fixed shift/load game FSM with a grid-aware controller. It owns the frog position on a ROWS×COLS grid with edge clamping on all four sides, plus lives, level progression, game-over/win, and optional button auto-repeat. It sits between the debounced button block and the playfield/display datapath; the datapath reads position and event strobes directly.

## Interface
- COLS, 8, grid columns (≥2)
- ROWS, 8, grid rows (≥2); row ROWS-1 = start row (bottom), row 0 = goal row
- START_COL, 3, respawn column (< COLS)
- LIVES, 3, lives per game (1..15)
- LEVELS, 4, levels per game (1..16)
- REPEAT_CYCLES, 0, held-button auto-repeat period in clocks; 0 = one move per press
- SC_STATEMACHINEFROG_CLOCK_50  in  1  system clock
- SC_STATEMACHINEFROG_RESET_InHigh  in  1  reset, asynchronous, active-high
- SC_STATEMACHINEFROG_startButton_InLow / upButton_InLow / downButton_InLow / leftButton_InLow / rightButton_InLow  in  1 each  debounced buttons, active-low
- SC_STATEMACHINEFROG_collision_InLow  in  1  frog overlaps hazard, active-low
- SC_STATEMACHINEFROG_row_Out  out  $clog2(ROWS)  frog row
- SC_STATEMACHINEFROG_col_Out  out  $clog2(COLS)  frog column
- SC_STATEMACHINEFROG_lives_Out  out  4  remaining lives
- SC_STATEMACHINEFROG_level_Out  out  4  current level, 0-based
- SC_STATEMACHINEFROG_clear_OutLow  out  1  one-cycle playfield clear (INIT)
- SC_STATEMACHINEFROG_move_OutLow  out  1  one-cycle strobe, position changed
- SC_STATEMACHINEFROG_dead_OutLow  out  1  one-cycle strobe, life lost
- SC_STATEMACHINEFROG_levelUp_OutLow  out  1  one-cycle strobe, level cleared
- SC_STATEMACHINEFROG_playing_Out / gameOver_Out / win_Out  out  1 each  status levels

## Operation
- States: RESET → IDLE. Each state and its exits:
  - IDLE: exits to INIT when start=0.
  - INIT: always exits to RELEASE.
  - CHECK: exits to DIE, INIT, MOVE, or stays in CHECK.
  - MOVE: exits to LEVELUP if the new row is 0, else RELEASE.
  - RELEASE: exits to DIE, CHECK, or stays in RELEASE.
  - DIE: exits to GAMEOVER or RELEASE.
  - LEVELUP: exits to GAMEOVER or RELEASE.
  - GAMEOVER: exits to INIT when start=0.
- INIT: row=ROWS-1, col=START_COL, lives=LIVES, level=0, win=0, clear_OutLow=0.
- CHECK priority, highest first:
  - collision=0 → DIE
  - start=0 → INIT
  - up → MOVE
  - down → MOVE
  - left → MOVE
  - right → MOVE
  - otherwise stay in CHECK
- Blocked moves: down at row ROWS-1, left at col 0, right at col COLS-1 are ignored. They fall through to the next lower-priority button; with no other button pressed, CHECK stays. No strobe is issued.
- MOVE: applies the latched direction and drives move_OutLow=0. Up = row-1, down = row+1, left = col-1, right = col+1. Position never leaves the grid and never wraps.
- RELEASE, in priority order:
  - collision=0 → DIE.
  - All five buttons high → CHECK.
  - REPEAT_CYCLES>0, latched direction still held, and repeat timer reaches REPEAT_CYCLES-1 → CHECK.
  - Otherwise stay in RELEASE.
- DIE: dead_OutLow=0, lives-1.
  - If lives was 1: → GAMEOVER with lives=0.
  - Else: respawn (row=ROWS-1, col=START_COL) → RELEASE.
- LEVELUP: levelUp_OutLow=0.
  - If level=LEVELS-1: win=1 → GAMEOVER.
  - Else: level+1, respawn → RELEASE.
- Status levels:
  - playing_Out=1 in CHECK, MOVE, RELEASE, DIE, LEVELUP.
  - gameOver_Out=1 in GAMEOVER.
  - win_Out holds from LEVELUP until the next INIT.

## Timing
- Strobes are Moore-decoded from the state register: exactly one cycle low per state visit.
- Position/lives/level are registered and update on the clock edge that leaves MOVE/INIT/DIE/LEVELUP.
- Press-to-move latency: 2 edges (CHECK→MOVE, MOVE→new position).
- Collision has priority over a simultaneous button or start press.
- A collision in MOVE is handled in the following state (RELEASE or LEVELUP→RELEASE).
- Reset values: state RESET; row ROWS-1; col START_COL; lives LIVES; level 0; every *_OutLow = 1; playing/gameOver/win = 0.
- Reset is honoured mid-operation in any state; no strobe may glitch low during reset.
- Repeat timer is cleared on RELEASE entry and whenever the latched direction is released.

## Structure
- Shared package sc_frog_pkg holds:
  - state encoding localparams (4-bit)
  - direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - width helper function for row/col
- Sub-module sc_repeat_timer: parametrised by REPEAT_CYCLES; clear/enable in, expired out; tied off when REPEAT_CYCLES=0.

## Test plan
- Reset, start pulse → clear_OutLow low 1 cycle; row=7, col=3, lives=3, level=0, playing=1.
- Hold left 5 presses from col 3 (release between each) → col 3,2,1,0,0; only 3 move strobes.
- REPEAT_CYCLES=4, hold right from col 3 → col steps every 6 cycles (4 repeat + CHECK + MOVE) and stops at 7; REPEAT_CYCLES=0 → single step.
- Collision together with up press in CHECK → dead strobe, no move, lives 3→2, respawn (7,3); third collision → gameOver=1, lives=0, start restarts.
- LEVELS=2: seven up presses reach row 0 → levelUp strobe, level=1, respawn; repeat → win=1, gameOver=1.
- Assert reset while in RELEASE holding a button → all outputs at reset values immediately; state IDLE after release.
